// File: rtl/nexus_pifo_pkg.sv
// Shared constants and types for the Nexus PIFO free-block manager.
package nexus_pifo_pkg;

  localparam int unsigned ADW         = 10;
  localparam int unsigned TW          = 4;
  localparam int unsigned SRAM_BLOCKS = 1024;
  localparam int unsigned TENANTS     = 16;
  localparam int unsigned QUOTA       = 64;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/nexus_block_reclaimer_if.sv
// Allocation / free handshake bundle between the reclaimer and its clients.
interface nexus_block_reclaimer_if #(
  parameter int unsigned ADW = nexus_pifo_pkg::ADW,
  parameter int unsigned TW  = nexus_pifo_pkg::TW
);

  logic           i_alloc_req;
  logic [TW-1:0]  i_alloc_tenant;
  logic           o_alloc_ack;
  logic           o_alloc_nack;
  logic [ADW-1:0] o_alloc_addr;
  logic           i_free_valid;
  logic [ADW-1:0] i_free_addr;
  logic [TW-1:0]  i_free_tenant;
  logic           o_free_ready;
  logic [ADW:0]   o_free_count;
  logic           o_init_done;
  logic           o_err_underflow;

  modport master (
    output i_alloc_req, i_alloc_tenant, i_free_valid, i_free_addr, i_free_tenant,
    input  o_alloc_ack, o_alloc_nack, o_alloc_addr, o_free_ready, o_free_count,
    input  o_init_done, o_err_underflow
  );

  modport slave (
    input  i_alloc_req, i_alloc_tenant, i_free_valid, i_free_addr, i_free_tenant,
    output o_alloc_ack, o_alloc_nack, o_alloc_addr, o_free_ready, o_free_count,
    output o_init_done, o_err_underflow
  );

endinterface

// File: rtl/nexus_free_fifo.sv
// Circular free list: push at tail, pop at head with a registered read of mem[head].
module nexus_free_fifo #(
  parameter int unsigned DEPTH = nexus_pifo_pkg::SRAM_BLOCKS,
  parameter int unsigned AW    = nexus_pifo_pkg::ADW
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] rd_data_o,
  output logic [AW-1:0] tail_o,
  output logic [AW:0]   count_o
);

  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] count_q;

  // Storage array carries no reset; INIT rewrites every entry.
  always_ff @(posedge i_clk) begin
    if (push_i) mem[tail_q] <= push_data_i;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + AW'(1);
      if (pop_i) begin
        rd_q   <= mem[head_q];
        head_q <= head_q + AW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign rd_data_o = rd_q;
  assign tail_o    = tail_q;
  assign count_o   = count_q;

endmodule

// File: rtl/nexus_block_reclaimer.sv
// Free-block manager: FSM, per-tenant occupancy quota and underflow detection
// around the circular free list of SRAM block addresses.
module nexus_block_reclaimer #(
  parameter int unsigned SRAM_BLOCKS = nexus_pifo_pkg::SRAM_BLOCKS,
  parameter int unsigned ADW         = nexus_pifo_pkg::ADW,
  parameter int unsigned TENANTS     = nexus_pifo_pkg::TENANTS,
  parameter int unsigned TW          = nexus_pifo_pkg::TW,
  parameter int unsigned QUOTA       = nexus_pifo_pkg::QUOTA
) (
  input logic                    i_clk,
  input logic                    i_arst_n,
  nexus_block_reclaimer_if.slave bus
);

  import nexus_pifo_pkg::*;

  localparam int unsigned CW  = ADW + 1;
  localparam int unsigned QCW = $clog2(QUOTA + 1);

  state_e         state_q;
  logic           init_done_q;
  logic           ack_q;
  logic           nack_q;
  logic           uflow_q;
  logic           ready_q;
  logic [QCW-1:0] tcnt_q [TENANTS];

  logic [ADW-1:0] tail;
  logic [ADW-1:0] rd_data;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt_c;
  logic           init_last_c;
  logic           grant_c;
  logic           free_acc_c;
  logic           uflow_c;
  logic           push_c;
  logic           pop_c;
  logic [ADW-1:0] push_data_c;

  // Decisions are taken against pre-cycle state only; a same-cycle free never feeds an alloc.
  always_comb begin
    init_last_c = 1'b0;
    grant_c     = 1'b0;
    free_acc_c  = 1'b0;
    uflow_c     = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    push_data_c = bus.i_free_addr;
    case (state_q)
      INIT: begin
        push_c      = 1'b1;
        push_data_c = tail;
        init_last_c = (count == CW'(SRAM_BLOCKS - 1));
      end
      RUN: begin
        grant_c    = bus.i_alloc_req && (count != '0) &&
                     (tcnt_q[bus.i_alloc_tenant] < QCW'(QUOTA));
        free_acc_c = bus.i_free_valid && ready_q;
        uflow_c    = free_acc_c && (tcnt_q[bus.i_free_tenant] == '0);
        push_c     = free_acc_c && !uflow_c;
        pop_c      = grant_c;
      end
      default: ;
    endcase
    count_nxt_c = count + CW'(push_c) - CW'(pop_c);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= INIT;
      init_done_q <= 1'b0;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      uflow_q     <= 1'b0;
      ready_q     <= 1'b0;
      for (int unsigned t = 0; t < TENANTS; t++) tcnt_q[t] <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (init_last_c) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
          ready_q <= init_last_c && (count_nxt_c != CW'(SRAM_BLOCKS));
        end
        RUN: begin
          ready_q <= (count_nxt_c != CW'(SRAM_BLOCKS));
        end
        default: state_q <= INIT;
      endcase
      ack_q   <= grant_c;
      nack_q  <= bus.i_alloc_req && !grant_c;
      uflow_q <= uflow_c;
      // Same-tenant alloc and free in one cycle cancel out.
      for (int unsigned t = 0; t < TENANTS; t++) begin
        if (grant_c && (bus.i_alloc_tenant == TW'(t)) &&
            !(push_c && (bus.i_free_tenant == TW'(t)))) begin
          tcnt_q[t] <= tcnt_q[t] + QCW'(1);
        end else if (push_c && (bus.i_free_tenant == TW'(t)) &&
                     !(grant_c && (bus.i_alloc_tenant == TW'(t)))) begin
          tcnt_q[t] <= tcnt_q[t] - QCW'(1);
        end
      end
    end
  end

  nexus_free_fifo #(
    .DEPTH (SRAM_BLOCKS),
    .AW    (ADW)
  ) u_free_fifo (
    .i_clk       (i_clk),
    .i_arst_n    (i_arst_n),
    .push_i      (push_c),
    .push_data_i (push_data_c),
    .pop_i       (pop_c),
    .rd_data_o   (rd_data),
    .tail_o      (tail),
    .count_o     (count)
  );

  assign bus.o_alloc_ack     = ack_q;
  assign bus.o_alloc_nack    = nack_q;
  assign bus.o_alloc_addr    = rd_data;
  assign bus.o_free_ready    = ready_q;
  assign bus.o_free_count    = count;
  assign bus.o_init_done     = init_done_q;
  assign bus.o_err_underflow = uflow_q;

endmodule

// File: tb/tb_nexus_block_reclaimer.sv
// Scoreboard bench for nexus_block_reclaimer: expected alloc results are queued at
// request time and popped when ack/nack appears; free-list state is modelled alongside.
module tb_nexus_block_reclaimer;

  localparam int BLOCKS = 1024;
  localparam int QUOTA  = 64;

  typedef struct packed {
    logic       ack;
    logic [9:0] addr;
  } exp_t;

  logic i_clk;
  logic i_arst_n;

  nexus_block_reclaimer_if bus_if ();

  nexus_block_reclaimer dut (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .bus      (bus_if)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int         n_total;
  int         n_bad;
  exp_t       sb [$];
  logic [9:0] m_list [$];
  int         m_tcnt [16];
  int         m_count;
  bit         m_run;
  bit         m_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, advance the model, sample at the next negedge.
  task automatic step(input logic req, input logic [3:0] at, input logic fv,
                      input logic [9:0] fa, input logic [3:0] ft);
    bit   g;
    bit   acc;
    bit   uf;
    exp_t e;
    bus_if.i_alloc_req    = req;
    bus_if.i_alloc_tenant = at;
    bus_if.i_free_valid   = fv;
    bus_if.i_free_addr    = fa;
    bus_if.i_free_tenant  = ft;
    g   = req && m_run && (m_count != 0) && (m_tcnt[at] < QUOTA);
    acc = fv && m_ready;
    uf  = acc && (m_tcnt[ft] == 0);
    if (req) begin
      e.ack  = g;
      e.addr = g ? m_list[0] : 10'd0;
      sb.push_back(e);
    end
    if (!m_run) begin
      m_list.push_back(10'(m_count));
      m_count++;
      if (m_count == BLOCKS) m_run = 1'b1;
    end else begin
      if (g) begin
        void'(m_list.pop_front());
        m_tcnt[at]++;
        m_count--;
      end
      if (acc && !uf) begin
        m_list.push_back(fa);
        m_tcnt[ft]--;
        m_count++;
      end
    end
    m_ready = m_run && (m_count != BLOCKS);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("resp_present", 32'(bus_if.o_alloc_ack | bus_if.o_alloc_nack), 32'(req));
    if (bus_if.o_alloc_ack || bus_if.o_alloc_nack) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("alloc_ack", 32'(bus_if.o_alloc_ack), 32'(e.ack));
        chk("alloc_nack", 32'(bus_if.o_alloc_nack), 32'(!e.ack));
        if (e.ack) chk("alloc_addr", 32'(bus_if.o_alloc_addr), 32'(e.addr));
      end
    end
    chk("free_count", 32'(bus_if.o_free_count), 32'(m_count));
    chk("init_done", 32'(bus_if.o_init_done), 32'(m_run));
    chk("free_ready", 32'(bus_if.o_free_ready), 32'(m_ready));
    chk("underflow", 32'(bus_if.o_err_underflow), 32'(uf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 10'd0, 4'd0);
  endtask

  task automatic do_reset();
    bus_if.i_alloc_req    = 1'b0;
    bus_if.i_alloc_tenant = 4'd0;
    bus_if.i_free_valid   = 1'b0;
    bus_if.i_free_addr    = 10'd0;
    bus_if.i_free_tenant  = 4'd0;
    i_arst_n = 1'b0;
    #2;
    chk("rst_ack", 32'(bus_if.o_alloc_ack), 32'd0);
    chk("rst_nack", 32'(bus_if.o_alloc_nack), 32'd0);
    chk("rst_addr", 32'(bus_if.o_alloc_addr), 32'd0);
    chk("rst_ready", 32'(bus_if.o_free_ready), 32'd0);
    chk("rst_count", 32'(bus_if.o_free_count), 32'd0);
    chk("rst_init_done", 32'(bus_if.o_init_done), 32'd0);
    chk("rst_underflow", 32'(bus_if.o_err_underflow), 32'd0);
    m_run   = 1'b0;
    m_ready = 1'b0;
    m_count = 0;
    m_list.delete();
    sb.delete();
    for (int t = 0; t < 16; t++) m_tcnt[t] = 0;
    repeat (2) @(negedge i_clk);
    i_arst_n = 1'b1;
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    i_arst_n = 1'b1;
    #1;

    // Init sequence, alloc during init nacked, free during init ignored.
    do_reset();
    for (int i = 0; i < BLOCKS; i++)
      step(i == 10, 4'd0, i == 20, 10'd5, 4'd0);
    step(1'b1, 4'd0, 1'b0, 10'd0, 4'd0);
    step(1'b1, 4'd0, 1'b0, 10'd0, 4'd0);
    // Underflow: tenant 7 holds nothing.
    step(1'b0, 4'd0, 1'b1, 10'd100, 4'd7);
    idle(2);
    // Tenant 2 holds 10, then a same-cycle same-tenant alloc+free; quota then proves tcnt.
    for (int i = 0; i < 10; i++) step(1'b1, 4'd2, 1'b0, 10'd0, 4'd0);
    step(1'b1, 4'd2, 1'b1, 10'd2, 4'd2);
    for (int i = 0; i < 55; i++) step(1'b1, 4'd2, 1'b0, 10'd0, 4'd0);

    // Quota: 65 back-to-back from tenant 3, then a free re-opens the quota.
    do_reset();
    idle(BLOCKS);
    for (int i = 0; i < 65; i++) step(1'b1, 4'd3, 1'b0, 10'd0, 4'd0);
    step(1'b0, 4'd0, 1'b1, 10'd5, 4'd3);
    step(1'b1, 4'd3, 1'b0, 10'd0, 4'd0);
    // Random mixed traffic.
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
           4'($urandom_range(0, 15)));

    // Pool exhaustion and same-cycle free/alloc at count 0.
    do_reset();
    idle(BLOCKS);
    for (int t = 0; t < 16; t++)
      for (int k = 0; k < QUOTA; k++) step(1'b1, 4'(t), 1'b0, 10'd0, 4'd0);
    step(1'b1, 4'd5, 1'b0, 10'd0, 4'd0);
    step(1'b1, 4'd0, 1'b1, 10'd17, 4'd0);
    step(1'b1, 4'd0, 1'b0, 10'd0, 4'd0);

    // Reset asserted mid-init restarts init in full.
    do_reset();
    idle(300);
    do_reset();
    idle(BLOCKS);
    step(1'b1, 4'd0, 1'b0, 10'd0, 4'd0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
